// File: rtl/jedro_1_sign_extender.sv
// Widens an M-bit field to N bits by sign or zero extension; 1-cycle registered latency, no backpressure.
// Define SIGN_EXT_COMB_OUT_EN for a zero-latency combinational path (clk_i/rstn_i then unused).
module jedro_1_sign_extender #(
  parameter int N = 32,
  parameter int M = 12
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [M-1:0] in_i,
  input  logic         zext_i,
  input  logic         valid_i,
  output logic [N-1:0] out_o,
  output logic         valid_o
);

  generate
    if (M < 1 || M > N) begin : g_bad_width
      $error("jedro_1_sign_extender: M (%0d) must satisfy 1 <= M <= N (%0d)", M, N);
    end
  endgenerate

  logic [N-1:0] ext;

  generate
    if (M == N) begin : g_pass
      // Nothing to extend, so the zero/sign selector is irrelevant.
      logic unused_zext;
      assign unused_zext = zext_i;
      assign ext         = in_i;
    end else begin : g_extend
      assign ext = {{(N-M){in_i[M-1] & ~zext_i}}, in_i};
    end
  endgenerate

`ifdef SIGN_EXT_COMB_OUT_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rstn_i;

  assign out_o   = ext;
  assign valid_o = valid_i;
`else
  logic [N-1:0] out_d, out_q;
  logic         valid_d, valid_q;

  // Hold on idle cycles so junk on in_i never reaches the output.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_i;
    if (valid_i) begin
      out_d = ext;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
`endif

endmodule

// File: tb/tb_jedro_1_sign_extender.sv
// Directed-vector bench for jedro_1_sign_extender at M=12, M=21 and M=N=32.
// Expectations follow the build: registered (default) or SIGN_EXT_COMB_OUT_EN.
module tb_jedro_1_sign_extender;

  logic        clk_i;
  logic        rstn_i;
  logic        zext_i;
  logic        valid_i;
  logic [11:0] in12;
  logic [20:0] in21;
  logic [31:0] in32;
  logic [31:0] out12, out21, out32;
  logic        v12, v21, v32;

  int n_checks = 0;
  int n_errors = 0;

  jedro_1_sign_extender #(.N(32), .M(12)) u_dut12 (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_i(in12), .zext_i(zext_i),
    .valid_i(valid_i), .out_o(out12), .valid_o(v12)
  );

  jedro_1_sign_extender #(.N(32), .M(21)) u_dut21 (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_i(in21), .zext_i(zext_i),
    .valid_i(valid_i), .out_o(out21), .valid_o(v21)
  );

  jedro_1_sign_extender #(.N(32), .M(32)) u_dut32 (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_i(in32), .zext_i(zext_i),
    .valid_i(valid_i), .out_o(out32), .valid_o(v32)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the point where the result of the currently driven inputs is visible.
  task automatic settle();
`ifdef SIGN_EXT_COMB_OUT_EN
    #1;
`else
    @(posedge clk_i);
    #1;
`endif
  endtask

  typedef struct {
    logic [31:0] in;
    logic        z;
    logic [31:0] exp;
  } vec_t;

  vec_t v12_tab[5];
  vec_t v21_tab[3];
  vec_t v32_tab[2];

  initial begin
    v12_tab[0] = '{32'h7FF, 1'b0, 32'h0000_07FF};
    v12_tab[1] = '{32'h800, 1'b0, 32'hFFFF_F800};
    v12_tab[2] = '{32'hFFF, 1'b0, 32'hFFFF_FFFF};
    v12_tab[3] = '{32'h800, 1'b1, 32'h0000_0800};
    v12_tab[4] = '{32'hFFF, 1'b1, 32'h0000_0FFF};
    v21_tab[0] = '{32'h10_0000, 1'b0, 32'hFFF0_0000};
    v21_tab[1] = '{32'h0F_FFFE, 1'b0, 32'h000F_FFFE};
    v21_tab[2] = '{32'h10_0000, 1'b1, 32'h0010_0000};
    v32_tab[0] = '{32'h8000_0000, 1'b0, 32'h8000_0000};
    v32_tab[1] = '{32'h8000_0000, 1'b1, 32'h8000_0000};

    rstn_i  = 1'b0;
    valid_i = 1'b0;
    zext_i  = 1'b0;
    in12    = '0;
    in21    = '0;
    in32    = '0;

`ifndef SIGN_EXT_COMB_OUT_EN
    #2;
    check("reset_out12", out12, 32'h0);
    check("reset_valid12", {31'b0, v12}, 32'h0);
    check("reset_out32", out32, 32'h0);
`endif
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (v12_tab[i]) begin
      in12    = v12_tab[i].in[11:0];
      zext_i  = v12_tab[i].z;
      valid_i = 1'b1;
      settle();
      check($sformatf("m12_out[%0d]", i), out12, v12_tab[i].exp);
      check($sformatf("m12_vld[%0d]", i), {31'b0, v12}, 32'h1);
    end

`ifndef SIGN_EXT_COMB_OUT_EN
    // Output must not move before the capturing edge.
    in12   = 12'h001;
    zext_i = 1'b0;
    #2;
    check("m12_latency_hold", out12, 32'h0000_0FFF);
    settle();
    check("m12_latency_new", out12, 32'h0000_0001);
`endif

    foreach (v21_tab[i]) begin
      in21    = v21_tab[i].in[20:0];
      zext_i  = v21_tab[i].z;
      valid_i = 1'b1;
      settle();
      check($sformatf("m21_out[%0d]", i), out21, v21_tab[i].exp);
    end

    foreach (v32_tab[i]) begin
      in32    = v32_tab[i].in;
      zext_i  = v32_tab[i].z;
      valid_i = 1'b1;
      settle();
      check($sformatf("m32_out[%0d]", i), out32, v32_tab[i].exp);
      check($sformatf("m32_vld[%0d]", i), {31'b0, v32}, 32'h1);
    end

`ifndef SIGN_EXT_COMB_OUT_EN
    // Mid-stream asynchronous reset.
    zext_i  = 1'b0;
    valid_i = 1'b1;
    in12    = 12'h800;
    settle();
    check("stream_800", out12, 32'hFFFF_F800);
    in12 = 12'h001;
    settle();
    check("stream_001", out12, 32'h0000_0001);
    in12 = 12'h7FF;
    #2;
    rstn_i  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("async_rst_out12", out12, 32'h0);
    check("async_rst_vld12", {31'b0, v12}, 32'h0);
    check("async_rst_out21", out21, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_idle_out", out12, 32'h0);
    check("post_rst_idle_vld", {31'b0, v12}, 32'h0);
    in12    = 12'h001;
    valid_i = 1'b1;
    settle();
    check("post_rst_out", out12, 32'h0000_0001);
    check("post_rst_vld", {31'b0, v12}, 32'h1);

    // Idle cycles with X inputs must leave the last result in place.
    in12 = 12'h800;
    settle();
    check("hold_seed", out12, 32'hFFFF_F800);
    valid_i = 1'b0;
    in12    = 'x;
    zext_i  = 1'bx;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("hold_out[%0d]", k), out12, 32'hFFFF_F800);
      check($sformatf("hold_vld[%0d]", k), {31'b0, v12}, 32'h0);
    end
`else
    // Combinational build: outputs track inputs immediately, reset has no effect.
    zext_i  = 1'b0;
    valid_i = 1'b0;
    in12    = 12'h7FF;
    #1;
    check("comb_idle_out", out12, 32'h0000_07FF);
    check("comb_idle_vld", {31'b0, v12}, 32'h0);
    in12 = 12'h800;
    #1;
    check("comb_follow_out", out12, 32'hFFFF_F800);
    rstn_i = 1'b0;
    #1;
    check("comb_rst_ignored", out12, 32'hFFFF_F800);
    rstn_i = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
